// File: rtl/rs_enc_param_pkg.sv
// Shared Reed-Solomon helpers: GF(2^w) arithmetic, generator polynomial
// construction and encoder state encodings.
package rs_enc_param_pkg;

   localparam int unsigned MAX_W    = 8;
   localparam int unsigned MAX_NPAR = 256;

   // Slot i holds the coefficient of x^i; slot npar holds the monic 1.
   typedef logic [MAX_NPAR-1:0][MAX_W-1:0] coef_vec_t;

   localparam logic [0:0] ST_DATA   = 1'b0;
   localparam logic [0:0] ST_PARITY = 1'b1;

   // Shift-and-reduce multiply in GF(2^w); poly includes the x^w term.
   function automatic int unsigned gf_mul(int unsigned a, int unsigned b,
                                          int unsigned poly, int unsigned w);
      int unsigned p;
      int unsigned x;
      p = 0;
      x = a;
      for (int unsigned i = 0; i < w; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ x;
         x = x << 1;
         if (((x >> w) & 1) != 0) x = x ^ poly;
      end
      return p;
   endfunction

   // g(x) = prod_{i=0..npar-1} (x + alpha^(fcr+i)), alpha = x.
   function automatic coef_vec_t gen_poly(int unsigned npar, int unsigned fcr,
                                          int unsigned poly, int unsigned w);
      coef_vec_t   g;
      int unsigned root;
      g    = '0;
      g[0] = MAX_W'(1);
      root = 1;
      for (int unsigned e = 0; e < fcr; e++) root = gf_mul(root, 2, poly, w);
      for (int unsigned i = 0; i < npar; i++) begin
         // Descend so g[j-1] is still the old value when folded into g[j].
         for (int j = int'(i) + 1; j >= 1; j--) begin
            g[j] = g[j-1] ^ MAX_W'(gf_mul(32'(g[j]), root, poly, w));
         end
         g[0] = MAX_W'(gf_mul(32'(g[0]), root, poly, w));
         root = gf_mul(root, 2, poly, w);
      end
      return g;
   endfunction

endpackage

// File: rtl/rs_enc_param_if.sv
// Streaming symbol interface between a symbol source and the RS encoder.
interface rs_enc_param_if #(
   parameter int unsigned SYM_W = 8,
   parameter int unsigned K     = 188
);
   localparam int unsigned KW = $clog2(K + 1);

   logic             CE;
   logic [SYM_W-1:0] input_byte;
   logic [KW-1:0]    k_len;
   logic             Ready;
   logic [SYM_W-1:0] Out_byte;
   logic             CEO;
   logic             Valid_out;
   logic             Par_flag;
   logic             Ovf_err;

   // Source side: drives symbols, watches the encoded stream.
   modport master (
      output CE, input_byte, k_len,
      input  Ready, Out_byte, CEO, Valid_out, Par_flag, Ovf_err
   );

   // Encoder side.
   modport slave (
      input  CE, input_byte, k_len,
      output Ready, Out_byte, CEO, Valid_out, Par_flag, Ovf_err
   );
endinterface

// File: rtl/rs_enc_param_gf_cmul.sv
// Multiply a symbol by an elaboration-time constant in GF(2^SYM_W).
module rs_gf_cmul
   import rs_enc_param_pkg::*;
#(
   parameter int unsigned COEF      = 1,
   parameter int unsigned SYM_W     = 8,
   parameter int unsigned PRIM_POLY = 'h11D
) (
   input  logic [SYM_W-1:0] din,
   output logic [SYM_W-1:0] prod
);

   // col[i] = COEF * alpha^i; the product is the XOR of the columns selected by din.
   logic [SYM_W-1:0] col [SYM_W];

   for (genvar i = 0; i < SYM_W; i++) begin : g_col
      assign col[i] = SYM_W'(gf_mul(32'(1) << i, COEF, PRIM_POLY, SYM_W));
   end

   // XOR network selected by the input bits.
   always_comb begin
      prod = '0;
      for (int i = 0; i < int'(SYM_W); i++) begin
         if (din[i]) prod = prod ^ col[i];
      end
   end

endmodule

// File: rtl/rs_enc_param.sv
// Systematic RS encoder: data symbols pass through with one cycle of latency,
// then NPAR parity symbols (highest degree first) are shifted out of the LFSR.
module rs_enc_param
   import rs_enc_param_pkg::*;
#(
   parameter int unsigned SYM_W     = 8,
   parameter int unsigned N         = 204,
   parameter int unsigned K         = 188,
   parameter int unsigned PRIM_POLY = 'h11D,
   parameter int unsigned FCR       = 0
) (
   input logic           clk,
   input logic           reset,
   rs_enc_param_if.slave bus
);

   localparam int unsigned NPAR = N - K;
   localparam int unsigned KW   = $clog2(K + 1);
   localparam int unsigned PW   = $clog2(NPAR);

   localparam coef_vec_t       GEN      = gen_poly(NPAR, FCR, PRIM_POLY, SYM_W);
   localparam logic [KW-1:0]   K_MAX    = KW'(K);
   localparam logic [PW-1:0]   PAR_LAST = PW'(NPAR - 1);

   logic [0:0]       state_q, state_d;
   logic [KW-1:0]    sym_cnt_q, sym_cnt_d;
   logic [KW-1:0]    klen_q, klen_d;
   logic [PW-1:0]    par_cnt_q, par_cnt_d;
   logic [SYM_W-1:0] r_q [NPAR];
   logic [SYM_W-1:0] r_d [NPAR];
   logic [SYM_W-1:0] out_q, out_d;
   logic             ceo_q, ceo_d;
   logic             valid_q, valid_d;
   logic             par_flag_q, par_flag_d;
   logic             ovf_q, ovf_d;

   logic [SYM_W-1:0] fb;
   logic [SYM_W-1:0] prod [NPAR];
   logic             first;
   logic [KW-1:0]    klen_in;
   logic [KW-1:0]    klen_cur;
   logic [KW-1:0]    cnt_inc;

   assign fb = bus.input_byte ^ r_q[NPAR-1];

   for (genvar i = 0; i < NPAR; i++) begin : g_tap
      rs_gf_cmul #(
         .COEF      (32'(GEN[i])),
         .SYM_W     (SYM_W),
         .PRIM_POLY (PRIM_POLY)
      ) u_cmul (
         .din  (fb),
         .prod (prod[i])
      );
   end

   // Length bookkeeping: out-of-range or zero k_len means a full-length codeword.
   always_comb begin
      first    = (sym_cnt_q == '0);
      klen_in  = ((bus.k_len == '0) || (bus.k_len > K_MAX)) ? K_MAX : bus.k_len;
      klen_cur = first ? klen_in : klen_q;
      cnt_inc  = sym_cnt_q + 1'b1;
   end

   // Next-state logic for the DATA/PARITY sequencer, LFSR and output stage.
   always_comb begin
      state_d    = state_q;
      sym_cnt_d  = sym_cnt_q;
      klen_d     = klen_q;
      par_cnt_d  = par_cnt_q;
      r_d        = r_q;
      out_d      = out_q;
      ceo_d      = 1'b0;
      valid_d    = valid_q;
      par_flag_d = 1'b0;
      ovf_d      = ovf_q;
      if (state_q == ST_DATA) begin
         if (bus.CE) begin
            r_d[0] = prod[0];
            for (int i = 1; i < int'(NPAR); i++) r_d[i] = r_q[i-1] ^ prod[i];
            out_d   = bus.input_byte;
            ceo_d   = 1'b1;
            valid_d = 1'b1;
            if (first) klen_d = klen_in;
            if (cnt_inc == klen_cur) begin
               state_d   = ST_PARITY;
               sym_cnt_d = '0;
               par_cnt_d = '0;
            end else begin
               sym_cnt_d = cnt_inc;
            end
         end else if (first) begin
            // Between codewords the frame envelope closes.
            valid_d = 1'b0;
         end
      end else begin
         // CE during parity is dropped and flagged.
         ovf_d = ovf_q | bus.CE;
         out_d = r_q[NPAR-1];
         for (int i = int'(NPAR) - 1; i >= 1; i--) r_d[i] = r_q[i-1];
         r_d[0]     = '0;
         ceo_d      = 1'b1;
         valid_d    = 1'b1;
         par_flag_d = 1'b1;
         if (par_cnt_q == PAR_LAST) begin
            state_d   = ST_DATA;
            par_cnt_d = '0;
         end else begin
            par_cnt_d = par_cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset aborts any codeword in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_DATA;
         sym_cnt_q  <= '0;
         klen_q     <= '0;
         par_cnt_q  <= '0;
         for (int i = 0; i < int'(NPAR); i++) r_q[i] <= '0;
         out_q      <= '0;
         ceo_q      <= 1'b0;
         valid_q    <= 1'b0;
         par_flag_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sym_cnt_q  <= sym_cnt_d;
         klen_q     <= klen_d;
         par_cnt_q  <= par_cnt_d;
         r_q        <= r_d;
         out_q      <= out_d;
         ceo_q      <= ceo_d;
         valid_q    <= valid_d;
         par_flag_q <= par_flag_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.Ready     = (state_q == ST_DATA);
   assign bus.Out_byte  = out_q;
   assign bus.CEO       = ceo_q;
   assign bus.Valid_out = valid_q;
   assign bus.Par_flag  = par_flag_q;
   assign bus.Ovf_err   = ovf_q;

endmodule

// File: tb/tb_rs_enc_param.sv
// Bench for rs_enc_param: a small RS(7,5) over GF(8) and the default RS(204,188).
module tb_rs_enc_param;

   logic clk;
   logic s_rst;
   logic b_rst;

   rs_enc_param_if #(.SYM_W(3), .K(5))   s_if ();
   rs_enc_param_if #(.SYM_W(8), .K(188)) b_if ();

   rs_enc_param #(
      .SYM_W(3), .N(7), .K(5), .PRIM_POLY('hB), .FCR(0)
   ) u_small (
      .clk   (clk),
      .reset (s_rst),
      .bus   (s_if)
   );

   rs_enc_param #(
      .SYM_W(8), .N(204), .K(188), .PRIM_POLY('h11D), .FCR(0)
   ) u_big (
      .clk   (clk),
      .reset (b_rst),
      .bus   (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Configuration of the two instances, index 0 = small, 1 = big.
   int cw    [2] = '{3, 8};
   int cpoly [2] = '{'hB, 'h11D};
   int cnpar [2] = '{2, 16};
   int cfcr  [2] = '{0, 0};
   int ck    [2] = '{5, 188};
   int kin   [2] = '{7, 255};
   int gtab  [2][257];

   int exp_sym [2][$];
   int exp_par [2][$];
   int obs_sym [2][$];
   int obs_par [2][$];
   int lens    [2][$];

   int n_assert = 0;
   int n_fail   = 0;

   int t1_out   [3] = '{1, 3, 2};
   int t1_ceo   [4] = '{1, 1, 1, 0};
   int t1_par   [4] = '{0, 1, 1, 0};
   int t1_valid [4] = '{1, 1, 1, 0};
   int t1_ready [4] = '{0, 0, 1, 1};
   int t2_out   [4] = '{1, 0, 7, 6};
   int dq [$];

   // Record every emitted symbol.
   always @(negedge clk) begin
      if (s_if.CEO === 1'b1) begin
         obs_sym[0].push_back(32'(s_if.Out_byte));
         obs_par[0].push_back(32'(s_if.Par_flag));
      end
      if (b_if.CEO === 1'b1) begin
         obs_sym[1].push_back(32'(b_if.Out_byte));
         obs_par[1].push_back(32'(b_if.Par_flag));
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int gmul(int a, int b, int which);
      int p = 0;
      int x = a;
      for (int i = 0; i < cw[which]; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ x;
         x = x << 1;
         if (((x >> cw[which]) & 1) != 0) x = x ^ cpoly[which];
      end
      return p;
   endfunction

   function automatic int alpha_pow(int e, int which);
      int r = 1;
      for (int i = 0; i < e; i++) r = gmul(r, 2, which);
      return r;
   endfunction

   // Full generator polynomial, gtab[w][npar] = 1.
   task automatic gen_g(input int which);
      int n = cnpar[which];
      for (int j = 0; j <= 256; j++) gtab[which][j] = 0;
      gtab[which][0] = 1;
      for (int i = 0; i < n; i++) begin
         int root = alpha_pow(cfcr[which] + i, which);
         for (int j = i + 1; j >= 0; j--)
            gtab[which][j] = ((j > 0) ? gtab[which][j-1] : 0) ^ gmul(gtab[which][j], root, which);
      end
   endtask

   function automatic int keff(int which, int k);
      return (k == 0 || k > ck[which]) ? ck[which] : k;
   endfunction

   // Expected codeword: data, then remainder of d(x)*x^npar divided by g(x).
   task automatic add_cw(input int which, input int d[$]);
      int n = cnpar[which];
      int k = d.size();
      int c[] = new[k + n];
      for (int j = 0; j < k + n; j++) c[j] = 0;
      for (int j = 0; j < k; j++) c[k + n - 1 - j] = d[j];
      for (int deg = k + n - 1; deg >= n; deg--) begin
         int coef = c[deg];
         if (coef != 0)
            for (int t = 0; t <= n; t++) c[deg - n + t] ^= gmul(coef, gtab[which][t], which);
      end
      for (int j = 0; j < k; j++) begin exp_sym[which].push_back(d[j]); exp_par[which].push_back(0); end
      for (int j = n - 1; j >= 0; j--) begin exp_sym[which].push_back(c[j]); exp_par[which].push_back(1); end
      lens[which].push_back(k + n);
   endtask

   task automatic set_in(input int which, input bit ce, input int klen, input int din);
      if (which == 0) begin
         s_if.CE = ce; s_if.k_len = 3'(klen); s_if.input_byte = 3'(din);
      end else begin
         b_if.CE = ce; b_if.k_len = 8'(klen); b_if.input_byte = 8'(din);
      end
   endtask

   // sel: 0 Out_byte, 1 CEO, 2 Valid_out, 3 Par_flag, 4 Ovf_err, 5 Ready
   function automatic logic [31:0] sig(int which, int sel);
      if (which == 0) begin
         case (sel)
            0: return 32'(s_if.Out_byte);
            1: return 32'(s_if.CEO);
            2: return 32'(s_if.Valid_out);
            3: return 32'(s_if.Par_flag);
            4: return 32'(s_if.Ovf_err);
            default: return 32'(s_if.Ready);
         endcase
      end else begin
         case (sel)
            0: return 32'(b_if.Out_byte);
            1: return 32'(b_if.CEO);
            2: return 32'(b_if.Valid_out);
            3: return 32'(b_if.Par_flag);
            4: return 32'(b_if.Ovf_err);
            default: return 32'(b_if.Ready);
         endcase
      end
   endfunction

   task automatic chk_reset_state(input int which, input string tag);
      chk({tag, "_out"}, sig(which, 0), 0);
      chk({tag, "_ceo"}, sig(which, 1), 0);
      chk({tag, "_valid"}, sig(which, 2), 0);
      chk({tag, "_par"}, sig(which, 3), 0);
      chk({tag, "_ovf"}, sig(which, 4), 0);
      chk({tag, "_ready"}, sig(which, 5), 1);
   endtask

   // Feed one codeword; optionally keep CE high through the parity slots.
   // Returns on the first cycle Ready is back, with CE low.
   task automatic send_cw(input int which, input int klen, input int d[$], input bit hold);
      int n = 0;
      add_cw(which, d);
      for (int i = 0; i < d.size(); i++) begin
         set_in(which, 1'b1, klen, d[i]);
         step();
      end
      while (sig(which, 5) != 1 && n < 2 * cnpar[which] + 4) begin
         set_in(which, hold, klen, $urandom);
         step();
         n++;
      end
      set_in(which, 1'b0, 0, 0);
      chk("ready_return", sig(which, 5), 1);
   endtask

   task automatic rand_cw(input int which, input bit hold);
      int k = $urandom_range(0, kin[which]);
      dq.delete();
      for (int i = 0; i < keff(which, k); i++) dq.push_back($urandom_range(0, (1 << cw[which]) - 1));
      send_cw(which, k, dq, hold);
   endtask

   task automatic wait_idle(input int which);
      int n = 0;
      while (sig(which, 2) != 0 && n < 50) begin step(); n++; end
      chk("valid_fall", sig(which, 2), 0);
   endtask

   task automatic clear_q(input int which);
      exp_sym[which].delete(); exp_par[which].delete();
      obs_sym[which].delete(); obs_par[which].delete();
      lens[which].delete();
   endtask

   // Compare stream against model; each codeword must also vanish at every root of g.
   task automatic compare_stream(input int which, input string tag);
      chk({tag, "_count"}, obs_sym[which].size(), exp_sym[which].size());
      if (obs_sym[which].size() == exp_sym[which].size()) begin
         int pos = 0;
         for (int i = 0; i < exp_sym[which].size(); i++) begin
            chk({tag, "_sym"}, obs_sym[which][i], exp_sym[which][i]);
            chk({tag, "_parflag"}, obs_par[which][i], exp_par[which][i]);
         end
         foreach (lens[which][c]) begin
            for (int r = 0; r < cnpar[which]; r++) begin
               int root = alpha_pow(cfcr[which] + r, which);
               int acc = 0;
               for (int s = pos; s < pos + lens[which][c]; s++)
                  acc = gmul(acc, root, which) ^ obs_sym[which][s];
               chk({tag, "_syndrome"}, acc, 0);
            end
            pos += lens[which][c];
         end
      end
      clear_q(which);
   endtask

   initial begin
      s_rst = 1'b0;
      b_rst = 1'b0;
      set_in(0, 1'b0, 0, 0);
      set_in(1, 1'b0, 0, 0);
      gen_g(0);
      gen_g(1);
      #2;
      s_rst = 1'b1;
      b_rst = 1'b1;
      step();
      step();
      chk_reset_state(0, "s_reset");
      chk_reset_state(1, "b_reset");
      s_rst = 1'b0;
      b_rst = 1'b0;
      step();

      // Single-symbol codeword: 1 -> 1, 3, 2
      set_in(0, 1'b1, 1, 1);
      step();
      set_in(0, 1'b0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) step();
         if (c < 3) chk("t1_out", sig(0, 0), t1_out[c]);
         chk("t1_ceo", sig(0, 1), t1_ceo[c]);
         chk("t1_par", sig(0, 3), t1_par[c]);
         chk("t1_valid", sig(0, 2), t1_valid[c]);
         chk("t1_ready", sig(0, 5), t1_ready[c]);
      end
      clear_q(0);

      // Two symbols 1,0 -> 1, 0, 7, 6
      dq = {1, 0};
      send_cw(0, 2, dq, 1'b0);
      wait_idle(0);
      chk("t2_count", obs_sym[0].size(), 4);
      if (obs_sym[0].size() == 4)
         for (int i = 0; i < 4; i++) chk("t2_sym", obs_sym[0][i], t2_out[i]);
      compare_stream(0, "t2");

      // CE held through parity, then an immediate back-to-back codeword
      dq = {5, 2, 7};
      send_cw(0, 3, dq, 1'b1);
      chk("ovf_set", sig(0, 4), 1);
      rand_cw(0, 1'b0);
      wait_idle(0);
      chk("ovf_sticky", sig(0, 4), 1);
      compare_stream(0, "ovf");

      // Random back-to-back codewords with random (incl. out-of-range) k_len
      for (int i = 0; i < 40; i++) rand_cw(0, 1'b0);
      wait_idle(0);
      compare_stream(0, "s_rand");

      // Full-length all-zero codeword with k_len=0
      dq.delete();
      for (int i = 0; i < 188; i++) dq.push_back(0);
      send_cw(1, 0, dq, 1'b0);
      wait_idle(1);
      chk("zero_ceo_count", obs_sym[1].size(), 204);
      if (obs_sym[1].size() == 204)
         for (int i = 188; i < 204; i++) chk("zero_parity", obs_sym[1][i], 0);
      compare_stream(1, "b_zero");

      for (int i = 0; i < 6; i++) rand_cw(1, 1'b0);
      wait_idle(1);
      compare_stream(1, "b_rand");
      chk("b_ovf_clear", sig(1, 4), 0);

      // Asynchronous reset 100 symbols into a full codeword
      for (int i = 0; i < 100; i++) begin
         set_in(1, 1'b1, 0, $urandom_range(0, 255));
         step();
      end
      set_in(1, 1'b0, 0, 0);
      #2;
      b_rst = 1'b1;
      #1;
      chk_reset_state(1, "b_async_rst");
      step();
      b_rst = 1'b0;
      clear_q(1);
      step();

      // Single symbol 1 -> parity equals g[15..0]
      dq = {1};
      send_cw(1, 1, dq, 1'b0);
      wait_idle(1);
      chk("gpoly_count", obs_sym[1].size(), 17);
      if (obs_sym[1].size() == 17) begin
         chk("gpoly_data", obs_sym[1][0], 1);
         for (int j = 0; j < 16; j++) chk("gpoly_coef", obs_sym[1][1 + j], gtab[1][15 - j]);
      end
      compare_stream(1, "b_gpoly");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_enc_param.md
Name: rs_enc_param

Overview:
- Parametrised systematic Reed-Solomon encoder over GF(2^SYM_W). It is the transmit-side companion to RS_dec and uses the same streaming interface: CE in, CEO and Valid_out out.
- Data symbols pass straight through. The block then appends NPAR parity symbols computed by an LFSR division by g(x).
- Supports run-time shortened codewords via k_len.
- Feeds RS_dec in the loopback/regression environment.

Parameters:
- SYM_W, 8, symbol width in bits (3..8).
- N, 204, full codeword length in symbols.
- K, 188, maximum data symbols per codeword. NPAR = N-K, must be even and ≥2.
- PRIM_POLY, 'h11D, field primitive polynomial, including the x^SYM_W term.
- FCR, 0, first consecutive root exponent. g(x) = prod_{i=0..NPAR-1} (x + alpha^(FCR+i)).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- CE  in  1  input symbol strobe
- input_byte  in  SYM_W  data symbol, valid when CE=1
- k_len  in  $clog2(K+1)  data symbols in this codeword; sampled on the first CE of a codeword
- Ready  out  1  high when CE is accepted (DATA state)
- Out_byte  out  SYM_W  registered output symbol
- CEO  out  1  output symbol strobe, one cycle per symbol
- Valid_out  out  1  high from the first to the last symbol of a codeword (frame envelope)
- Par_flag  out  1  high while Out_byte carries a parity symbol
- Ovf_err  out  1  sticky: CE seen while Ready=0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: all outputs 0 except Ready=1. LFSR registers, counters and latched length all clear; state=DATA.
- LFSR: registers r[0..NPAR-1], each SYM_W wide. Generator coefficients g[0..NPAR-1] are elaboration-time constants; the monic term is implicit.
- DATA state, on CE=1:
  - fb = input_byte ^ r[NPAR-1]
  - r[i] <= r[i-1] ^ gfmul(fb, g[i])
  - r[0] <= gfmul(fb, g[0])
  - Next cycle: Out_byte=input_byte, CEO=1, Valid_out=1, Par_flag=0. Latency is 1 cycle.
- DATA state, CE=0: registers hold; CEO=0; Valid_out holds its current value mid-frame.
- Length handling:
  - On the first CE of a codeword (sym_cnt==0), latch klen_q = k_len. If k_len==0 or k_len>K, latch K.
  - sym_cnt increments on each accepted CE.
  - The CE that brings sym_cnt to klen_q moves the state to PARITY in the same edge. Ready drops the following cycle.
- PARITY state (free-running, no CE needed):
  - Each cycle: Out_byte <= r[NPAR-1], r shifts up by one, r[0] <= 0.
  - CEO=1, Valid_out=1, Par_flag=1.
  - After NPAR cycles: state returns to DATA, Ready=1, counters clear. Valid_out falls on the cycle after the last parity symbol.
  - Parity order: highest-degree coefficient first.
- Ovf_err: CE=1 while Ready=0 is ignored (no LFSR or counter effect) and sets Ovf_err. It clears only on reset.
- Back-to-back codewords: CE may be asserted the first cycle Ready returns high. No dead cycles are required beyond the NPAR parity slots.
- Reset mid-codeword: immediate abort, no partial parity emitted. The next CE starts a new codeword.
- gfmul: combinational shift-and-reduce by PRIM_POLY. Constant-multiplier form is acceptable since g[] is constant.

Decomposition:
- Package rs_pkg:
  - gf_mul(a, b, poly, w) function
  - gen_poly(npar, fcr, poly, w) elaboration function returning the coefficient array
  - state enum {DATA, PARITY}
  - Shared with future RS_dec parametrisation.
- One sub-module is natural: rs_gf_cmul (constant GF multiplier, parameters COEF, SYM_W, PRIM_POLY), instantiated NPAR times.

Test Plan:
- Config SYM_W=3, PRIM_POLY='hB, N=7, K=5, FCR=0, NPAR=2, so g(x)=x^2+3x+2. Stimulus: k_len=1, one CE with input 1. Required: Out_byte 1 (CEO=1, Par_flag=0), then 3, then 2 (Par_flag=1); Valid_out high for 3 cycles; Ready low for 2 cycles.
- Same config, k_len=2, inputs 1,0. Required: out 1,0,7,6.
- Default config (RS(204,188)), 188 zero symbols with k_len=0 (treated as K). Required: 16 parity symbols all 0; 204 CEO pulses total.
- CE held high through parity. Required: Ovf_err=1 and stays 1; parity values unchanged from the clean run; the next codeword after Ready returns encodes correctly.
- Reset asserted at data symbol 100 of 188. Required: all outputs 0 and Ready=1 asynchronously. A following single-symbol k_len=1 codeword with input 1 yields parity equal to g[15..0].
- Loopback: encoder output into RS_dec with 8 random symbol corruptions per codeword, 1000 codewords. Required: decoded data equals the original data.
